// File: rtl/vwb_pkg.sv
// Shared definitions for the vector register-file writeback sequencer:
// vtype field layout, SEW/LMUL codes, FSM states and placement helpers.
package vwb_pkg;

  localparam int VLEN = 64;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;
  localparam logic [1:0] SEW_64 = 2'b11;

  localparam logic [2:0] LMUL_1 = 3'b000;
  localparam logic [2:0] LMUL_2 = 3'b001;
  localparam logic [2:0] LMUL_4 = 3'b010;
  localparam logic [2:0] LMUL_8 = 3'b011;

  // vtype layout, shared with the register-file config path
  localparam int VT_VALID_BIT = 6;
  localparam int VT_SEW_MSB   = 4;
  localparam int VT_SEW_LSB   = 3;
  localparam int VT_LMUL_MSB  = 2;
  localparam int VT_LMUL_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Index of the last element slot in one register word (epr - 1).
  function automatic logic [2:0] epr_m1_f(input logic [1:0] sew);
    logic [2:0] r;
    case (sew)
      SEW_8:   r = 3'd7;
      SEW_16:  r = 3'd3;
      SEW_32:  r = 3'd1;
      SEW_64:  r = 3'd0;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // VLMAX = LMUL * 64/SEW, as a power of two (1..64).
  function automatic logic [7:0] vlmax_f(input logic [1:0] sew, input logic [1:0] lmul);
    logic [2:0] e;
    e = 3'd3 + {1'b0, lmul} - {1'b0, sew};
    return 8'd1 << e;
  endfunction

endpackage

// File: rtl/vwb_packer.sv
// Merges one SEW-wide element into the pack word at its slot, and fills every
// bit above that element with ones when it is the final element.
module vwb_packer
  import vwb_pkg::*;
(
  input  logic [VLEN-1:0] pack_i,
  input  logic [VLEN-1:0] elem_i,
  input  logic [1:0]      sew_i,
  input  logic [2:0]      slot_i,
  input  logic            tail_i,
  output logic [VLEN-1:0] pack_o
);

  localparam logic [VLEN-1:0] ONE = {{(VLEN-1){1'b0}}, 1'b1};

  logic [6:0]      sew_bits;
  logic [6:0]      lsb;
  logic [6:0]      top;
  logic [VLEN-1:0] lane_mask;
  logic [VLEN-1:0] below_top;

  // Shifting by the full width yields 0, so the masks stay correct at SEW64.
  always_comb begin
    sew_bits  = 7'd8 << sew_i;
    lsb       = {4'd0, slot_i} << ({1'b0, sew_i} + 3'd3);
    top       = lsb + sew_bits;
    lane_mask = ((ONE << sew_bits) - ONE) << lsb;
    below_top = (ONE << top) - ONE;
    pack_o    = (pack_i & ~lane_mask) | ((elem_i << lsb) & lane_mask);
    if (tail_i) begin
      pack_o = pack_o | ~below_top;
    end
  end

endmodule

// File: rtl/vreg_wb_sequencer.sv
// Writeback sequencer: collects element results for one vector instruction and
// writes packed 64-bit words to each destination register of the LMUL group.
//
// state   | meaning
// IDLE    | waiting for start; also the cycle that presents a late done pulse
// COLLECT | accepting elements, writing each completed word the next cycle
// DONE    | last word written (or config rejected); finish the done pulse
module vreg_wb_sequencer
  import vwb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  vd,
  input  logic [6:0]  vl,
  input  logic [6:0]  vtype,
  input  logic        elem_valid,
  input  logic [63:0] elem_data,
  output logic        elem_ready,
  output logic        wen,
  output logic [4:0]  wa,
  output logic [63:0] wd,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e          state_q;
  logic [4:0]      vd_q;
  logic [6:0]      vl_q;
  logic [1:0]      sew_q;
  logic [6:0]      idx_q;
  logic [2:0]      slot_q;
  logic [2:0]      reg_off_q;
  logic [VLEN-1:0] pack_q;
  logic [VLEN-1:0] pack_d;
  logic            elem_ready_q, wen_q, busy_q, done_q, err_q;
  logic [4:0]      wa_q;
  logic [VLEN-1:0] wd_q;

  logic [1:0] sew_in;
  logic [2:0] lmul_in;
  logic [4:0] align_mask;
  logic       cfg_bad;
  logic       accept, last_elem, last_slot, word_done;
  logic       unused_vtype;

  assign sew_in       = vtype[VT_SEW_MSB:VT_SEW_LSB];
  assign lmul_in      = vtype[VT_LMUL_MSB:VT_LMUL_LSB];
  assign unused_vtype = vtype[5];
  assign align_mask   = (5'd1 << lmul_in[1:0]) - 5'd1;
  assign cfg_bad      = !vtype[VT_VALID_BIT] || (lmul_in > LMUL_8)
                        || ((vd & align_mask) != 5'd0)
                        || ({1'b0, vl} > vlmax_f(sew_in, lmul_in[1:0]));

  assign accept    = elem_ready_q && elem_valid;
  assign last_elem = (idx_q == vl_q - 7'd1);
  assign last_slot = (slot_q == epr_m1_f(sew_q));
  assign word_done = last_slot || last_elem;

  vwb_packer u_packer (
    .pack_i (pack_q),
    .elem_i (elem_data),
    .sew_i  (sew_q),
    .slot_i (slot_q),
    .tail_i (last_elem),
    .pack_o (pack_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      vd_q         <= '0;
      vl_q         <= '0;
      sew_q        <= '0;
      idx_q        <= '0;
      slot_q       <= '0;
      reg_off_q    <= '0;
      pack_q       <= '0;
      elem_ready_q <= 1'b0;
      wen_q        <= 1'b0;
      wa_q         <= '0;
      wd_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (start) begin
            vd_q      <= vd;
            vl_q      <= vl;
            sew_q     <= sew_in;
            idx_q     <= '0;
            slot_q    <= '0;
            reg_off_q <= '0;
            pack_q    <= '0;
            busy_q    <= 1'b1;
            if (cfg_bad || (vl == 7'd0)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= cfg_bad;
            end else begin
              state_q      <= COLLECT;
              elem_ready_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            idx_q <= idx_q + 7'd1;
            if (word_done) begin
              wen_q     <= 1'b1;
              wa_q      <= vd_q + {2'b00, reg_off_q};
              wd_q      <= pack_d;
              pack_q    <= '0;
              slot_q    <= '0;
              reg_off_q <= reg_off_q + 3'd1;
            end else begin
              pack_q <= pack_d;
              slot_q <= slot_q + 3'd1;
            end
            if (last_elem) begin
              elem_ready_q <= 1'b0;
              state_q      <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          // a rejected/empty start already pulsed done on entry
          if (done_q) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign elem_ready = elem_ready_q;
  assign wen        = wen_q;
  assign wa         = wa_q;
  assign wd         = wd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/vreg_wb_sequencer.md
# vreg_wb_sequencer

Writeback sequencer that drives the write port of the vector register file. For one vector instruction it accepts SEW-wide element results from the execution lanes over a valid/ready stream, packs them into 64-bit register words, and issues one write per destination register of the LMUL group. It computes element-to-register placement from vl and vtype, and fills the tail of the last partially-filled register.

## Interface
- VLEN, 64: register width in bits; fixed for this design.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins an instruction; ignored while busy=1.
- vd  in  5  destination base register; sampled on start.
- vl  in  7  element count; sampled on start.
- vtype  in  7  bit6 valid, [4:3] SEW code (00=8, 01=16, 10=32, 11=64), [2:0] LMUL code (000=1, 001=2, 010=4, 011=8, others illegal); sampled on start.
- elem_valid  in  1  element result valid.
- elem_data  in  64  element result; only the low SEW bits are used.
- elem_ready  out  1  sequencer accepts an element this cycle.
- wen  out  1  register-file write enable.
- wa  out  5  register-file write address.
- wd  out  64  register-file write data.
- busy  out  1  instruction in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid only with done; 1 means the configuration was illegal.

## Operation
- Derived values: epr = 64/SEW elements per register; VLMAX = LMUL*epr.
- Element i goes to register vd + i/epr, bits [(i mod epr)*SEW +: SEW].
- Illegal configuration, checked on start:
  - vtype[6]=0, or
  - LMUL code > 011, or
  - vd mod LMUL ≠ 0, or
  - vl > VLMAX.
- On an illegal configuration: no element is accepted, no write is issued, and done=1 with err=1 is asserted the cycle after start.
- vl=0: no writes; done=1 with err=0 the cycle after start.
- States:
  - IDLE to COLLECT on a legal start with vl>0.
  - IDLE to DONE on an illegal start or vl=0.
  - COLLECT to DONE when element vl-1 is accepted.
  - DONE to IDLE unconditionally.
- In COLLECT: elem_ready=1. The packer accumulates each accepted element in a pack register at its placement and advances an element index.
- A register word is complete when the accepted element is the last slot (i mod epr = epr-1) or is element vl-1. The next cycle then drives wen=1, wa = that register, wd = the packed word, and the pack register clears.
- Tail-agnostic policy: bits above the last valid element in the final word are written as all-ones.
- Registers of the group beyond ceil(vl/epr) are never written.
- busy=1 from the cycle after start through the DONE cycle.
- Reset mid-instruction: return to IDLE, discard packed data, no further writes.

## Timing
- Reset values: elem_ready=0, wen=0, wa=0, wd=0, busy=0, done=0, err=0. State is IDLE and the pack register is 0.
- All outputs are registered. elem_ready is 1 from cycle start+1.
- Write latency: wen is asserted 1 cycle after the accept that completes a word.
- Throughput is one element per cycle; a write cycle never stalls accepts.
- done is asserted 1 cycle after the last write, which is 2 cycles after the last accept.
- elem_valid=0 holds the state; gaps are allowed at any point.
- elem_data must stay stable only in the accept cycle.

## Structure
- Shared package vwb_pkg holds:
  - SEW and LMUL code localparams;
  - the state enum {IDLE, COLLECT, DONE};
  - the VLEN constant;
  - the vtype field bit positions, also used by the register-file config path.
- Sub-module vwb_packer: SEW-indexed byte-lane merge of one element into the pack register, plus the all-ones tail fill. It is purely combinational and instantiated once.

## Test plan
- vtype=0x5B (SEW64, LMUL8), vd=8, vl=3, start at cycle 0:
  - accepts in cycles 1–3;
  - writes wa=8/9/10 in cycles 2–4 with wd equal to the elements;
  - done in cycle 5, err=0.
- SEW8 LMUL1 (vtype=0x40), vd=2, vl=5, elements 0x11..0x55:
  - a single write wa=2, wd=0xFFFFFF5544332211;
  - done 2 cycles after the last accept.
- SEW16 LMUL2 (vtype=0x49), vd=4, vl=6, elem_valid toggling each cycle:
  - writes wa=4 with a full word, then wa=5 with the upper 32 bits all-ones;
  - no write to any other register.
- Illegal cases, each giving done+err the cycle after start, no wen, and elem_ready always 0:
  - vd=3 with LMUL4;
  - vtype[6]=0;
  - vl=9 with SEW64 LMUL8.
- vl=0 gives done with err=0, no wen. A start during busy is ignored: the in-flight write sequence is unchanged.
- rst asserted after 2 of 4 SEW32 elements: all outputs 0 immediately, no further wen. A new start after reset completes normally.
